// File: rtl/instr_encoder_loader.sv
// Encodes decoded RV32I instruction fields into 32-bit words and writes them
// sequentially into instruction memory, one word per two cycles.
module instr_encoder_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_func3,
  input  logic              in_f7b5,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [31:0]       imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err_kind,
  output logic              overflow
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    K_LW     = 4'd0,
    K_SW     = 4'd1,
    K_RTYPE  = 4'd2,
    K_ITYPE  = 4'd3,
    K_LUI    = 4'd4,
    K_AUIPC  = 4'd5,
    K_JALR   = 4'd6,
    K_JAL    = 4'd7,
    K_BRANCH = 4'd8
  } kind_t;

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

  state_t          state;
  logic            last_pending;
  logic [31:0]     enc_word;
  logic            enc_illegal;
  logic [ADDR_W:0] count_inc;

  assign count_inc = count + 1'b1;

  // Combinational field-to-word encoder; illegal kinds become a NOP
  always_comb begin
    enc_word    = '0;
    enc_illegal = 1'b0;
    case (in_kind)
      K_LW:     enc_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, OP_LOAD};
      K_SW:     enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OP_STORE};
      K_RTYPE:  enc_word = {1'b0, in_f7b5, 5'b0, in_rs2, in_rs1, in_func3, in_rd, OP_RTYPE};
      K_ITYPE: begin
        if (in_func3 == 3'b001 || in_func3 == 3'b101)
          enc_word = {1'b0, in_f7b5, 5'b0, in_imm[4:0], in_rs1, in_func3, in_rd, OP_ITYPE};
        else
          enc_word = {in_imm[11:0], in_rs1, in_func3, in_rd, OP_ITYPE};
      end
      K_LUI:    enc_word = {in_imm[31:12], in_rd, OP_LUI};
      K_AUIPC:  enc_word = {in_imm[31:12], in_rd, OP_AUIPC};
      K_JALR:   enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR};
      K_JAL:    enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
      K_BRANCH: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_func3,
                            in_imm[4:1], in_imm[11], OP_BRANCH};
      default: begin
        enc_word    = 32'h0000_0013;
        enc_illegal = 1'b1;
      end
    endcase
  end

  // Session FSM with registered handshake, write port and status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      in_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= BASE_ADDR;
      imem_wdata   <= '0;
      count        <= '0;
      done         <= 1'b0;
      err_kind     <= 1'b0;
      overflow     <= 1'b0;
      last_pending <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= ACCEPT;
            count    <= '0;
            done     <= 1'b0;
            err_kind <= 1'b0;
            overflow <= 1'b0;
            // ACCEPT is only entered with count below capacity
            in_ready <= 1'b1;
          end
        end
        ACCEPT: begin
          if (in_valid && in_ready) begin
            state        <= WRITE;
            in_ready     <= 1'b0;
            imem_we      <= 1'b1;
            imem_addr    <= BASE_ADDR + (32'(count) << 2);
            imem_wdata   <= enc_word;
            last_pending <= in_last;
            if (enc_illegal) err_kind <= 1'b1;
          end
        end
        WRITE: begin
          imem_we <= 1'b0;
          count   <= count_inc;
          if (last_pending) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (count_inc == DEPTH) begin
            state    <= DONE;
            done     <= 1'b1;
            overflow <= 1'b1;
          end else begin
            state    <= ACCEPT;
            in_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed literal checks plus randomized
// sessions compared every cycle against a behavioural model.
module tb_instr_encoder_loader;

  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_kind = '0;
  logic [4:0]    in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]    in_func3 = '0;
  logic          in_f7b5 = 1'b0;
  logic [31:0]   in_imm = '0;
  logic          in_last = 1'b0;
  logic          imem_we;
  logic [31:0]   imem_addr, imem_wdata;
  logic [AW:0]   count;
  logic          done, err_kind, overflow;

  int checks = 0;
  int failures = 0;
  bit acc;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_func3(in_func3), .in_f7b5(in_f7b5), .in_imm(in_imm), .in_last(in_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count), .done(done), .err_kind(err_kind), .overflow(overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Reference encoder built from shifted/masked fields
  function automatic logic [31:0] ref_enc(input int unsigned k, input int unsigned rd_,
      input int unsigned rs1_, input int unsigned rs2_, input int unsigned f3_,
      input int unsigned f7_, input logic [31:0] im);
    int unsigned i;
    int unsigned w;
    i = im;
    case (k)
      0: w = ((i & 'hFFF) << 20) | (rs1_ << 15) | (2 << 12) | (rd_ << 7) | 'h03;
      1: w = (((i >> 5) & 'h7F) << 25) | (rs2_ << 20) | (rs1_ << 15) | (2 << 12)
             | ((i & 31) << 7) | 'h23;
      2: w = (f7_ << 30) | (rs2_ << 20) | (rs1_ << 15) | (f3_ << 12) | (rd_ << 7) | 'h33;
      3: begin
        if (f3_ == 1 || f3_ == 5)
          w = (f7_ << 30) | ((i & 31) << 20) | (rs1_ << 15) | (f3_ << 12) | (rd_ << 7) | 'h13;
        else
          w = ((i & 'hFFF) << 20) | (rs1_ << 15) | (f3_ << 12) | (rd_ << 7) | 'h13;
      end
      4: w = (i & 'hFFFFF000) | (rd_ << 7) | 'h37;
      5: w = (i & 'hFFFFF000) | (rd_ << 7) | 'h17;
      6: w = ((i & 'hFFF) << 20) | (rs1_ << 15) | (rd_ << 7) | 'h67;
      7: w = (((i >> 20) & 1) << 31) | (((i >> 1) & 'h3FF) << 21) | (((i >> 11) & 1) << 20)
             | (((i >> 12) & 'hFF) << 12) | (rd_ << 7) | 'h6F;
      8: w = (((i >> 12) & 1) << 31) | (((i >> 5) & 'h3F) << 25) | (rs2_ << 20) | (rs1_ << 15)
             | (f3_ << 12) | (((i >> 1) & 'hF) << 8) | (((i >> 11) & 1) << 7) | 'h63;
      default: w = 'h13;
    endcase
    return w;
  endfunction

  // Behavioural model: accepting / writing / idle session with counters
  bit          armed = 0;
  bit          m_ready, m_we, m_last, m_done, m_err, m_ovf;
  int unsigned m_count;
  logic [31:0] m_addr, m_data;

  always @(posedge clk) begin
    if (!rst_n) begin
      armed <= 1; m_ready <= 0; m_we <= 0; m_last <= 0; m_done <= 0;
      m_err <= 0; m_ovf <= 0; m_count <= 0;
    end else if (m_we) begin
      m_we    <= 0;
      m_count <= m_count + 1;
      if (m_last) m_done <= 1;
      else if (m_count + 1 == DEPTH) begin m_done <= 1; m_ovf <= 1; end
      else m_ready <= 1;
    end else if (m_ready) begin
      if (in_valid) begin
        m_we    <= 1;
        m_ready <= 0;
        m_addr  <= BASE + 4 * m_count;
        m_data  <= ref_enc(in_kind, in_rd, in_rs1, in_rs2, in_func3, in_f7b5, in_imm);
        m_last  <= in_last;
        if (in_kind > 8) m_err <= 1;
      end
    end else if (start) begin
      m_ready <= 1; m_count <= 0; m_done <= 0; m_err <= 0; m_ovf <= 0;
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (armed) begin
      chk("in_ready", 32'(in_ready), 32'(m_ready));
      chk("imem_we", 32'(imem_we), 32'(m_we));
      chk("count", 32'(count), m_count);
      chk("done", 32'(done), 32'(m_done));
      chk("err_kind", 32'(err_kind), 32'(m_err));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (m_we) begin
        chk("imem_addr", imem_addr, m_addr);
        chk("imem_wdata", imem_wdata, m_data);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present one instruction; returns at the negedge of its write cycle if accepted
  task automatic send(input int unsigned k, input int unsigned r, input int unsigned s1,
      input int unsigned s2, input int unsigned f, input int unsigned f7,
      input logic [31:0] im, input bit last, input int budget, output bit accepted);
    in_kind = 4'(k); in_rd = 5'(r); in_rs1 = 5'(s1); in_rs2 = 5'(s2);
    in_func3 = 3'(f); in_f7b5 = f7[0]; in_imm = im; in_last = last;
    in_valid = 1'b1;
    accepted = 1'b0;
    for (int t = 0; t < budget; t++) begin
      if (in_ready) begin
        accepted = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_imem_we", 32'(imem_we), 0);
    chk("rst_imem_addr", imem_addr, BASE);
    chk("rst_imem_wdata", imem_wdata, 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_flags", {29'(0), done, err_kind, overflow}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single ITYPE with last
    pulse_start();
    send(3, 1, 0, 0, 0, 0, 32'd5, 1, 20, acc);
    chk("t1_acc", 32'(acc), 1);
    chk("t1_we", 32'(imem_we), 1);
    chk("t1_addr", imem_addr, 32'h0);
    chk("t1_data", imem_wdata, 32'h0050_0093);
    @(negedge clk);
    chk("t1_done", 32'(done), 1);
    chk("t1_count", 32'(count), 1);

    // SW, RTYPE (SUB), BRANCH
    pulse_start();
    send(1, 0, 1, 2, 0, 0, 32'd8, 0, 20, acc);
    chk("t2_sw_data", imem_wdata, 32'h0020_A423);
    chk("t2_sw_addr", imem_addr, 32'h0);
    chk("t2_sw_ready", 32'(in_ready), 0);
    send(2, 3, 1, 2, 0, 1, 32'd0, 0, 20, acc);
    chk("t2_r_data", imem_wdata, 32'h4020_81B3);
    chk("t2_r_addr", imem_addr, 32'h4);
    chk("t2_r_ready", 32'(in_ready), 0);
    send(8, 0, 1, 2, 0, 0, 32'hFFFF_FFFC, 1, 20, acc);
    chk("t2_b_data", imem_wdata, 32'hFE20_8EE3);
    chk("t2_b_addr", imem_addr, 32'h8);
    chk("t2_b_ready", 32'(in_ready), 0);
    @(negedge clk);
    chk("t2_done", 32'(done), 1);
    chk("t2_count", 32'(count), 3);

    // JAL, LUI, illegal kind
    pulse_start();
    send(7, 1, 0, 0, 0, 0, 32'h800, 0, 20, acc);
    chk("t3_jal", imem_wdata, 32'h0010_00EF);
    send(4, 5, 0, 0, 0, 0, 32'h1234_5000, 0, 20, acc);
    chk("t3_lui", imem_wdata, 32'h1234_52B7);
    send(12, 0, 0, 0, 0, 0, 32'h0, 1, 20, acc);
    chk("t3_nop", imem_wdata, 32'h0000_0013);
    @(negedge clk);
    chk("t3_err", 32'(err_kind), 1);
    chk("t3_count", 32'(count), 3);

    // capacity exhaustion without last
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      send(3, i + 1, 0, 0, 0, 0, 32'(i), 0, 20, acc);
      chk("t4_acc", 32'(acc), 1);
      chk("t4_addr", imem_addr, 32'(4 * i));
    end
    @(negedge clk);
    send(3, 9, 0, 0, 0, 0, 32'd9, 0, 8, acc);
    chk("t4_fifth_rejected", 32'(acc), 0);
    chk("t4_overflow", 32'(overflow), 1);
    chk("t4_done", 32'(done), 1);
    chk("t4_count", 32'(count), 4);
    chk("t4_ready", 32'(in_ready), 0);

    // start ignored in ACCEPT, then reset during a WRITE cycle
    pulse_start();
    send(0, 2, 3, 0, 0, 0, 32'd16, 0, 20, acc);
    @(negedge clk);
    pulse_start();
    chk("t5_count_kept", 32'(count), 1);
    chk("t5_ready_kept", 32'(in_ready), 1);
    send(6, 1, 2, 0, 0, 0, 32'd12, 0, 20, acc);
    chk("t5_we_before_rst", 32'(imem_we), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t5_rst_we", 32'(imem_we), 0);
    chk("t5_rst_count", 32'(count), 0);
    chk("t5_rst_addr", imem_addr, BASE);
    chk("t5_rst_data", imem_wdata, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_no_write", 32'(imem_we), 0);
    end

    // randomized sessions
    for (int s = 0; s < 40; s++) begin
      int unsigned n;
      pulse_start();
      n = $urandom_range(1, 6);
      for (int unsigned j = 0; j < n; j++) begin
        int unsigned k;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        if ($urandom_range(0, 9) == 0) pulse_start();
        k = ($urandom_range(0, 7) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
        send(k, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 7), $urandom_range(0, 1), $urandom, j == n - 1, 10, acc);
      end
      repeat (3) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
